stream_minmax: RTL and testbench



---
 rtl/stream_minmax.sv | 113 +++++++++++
 tb/tb_stream_minmax.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_minmax.sv
// Running signed min/max/count over a valid/ready word stream; result presented on the word flagged last.
// slt: overflow-corrected signed less-than used for every magnitude decision in the datapath.

// Purpose: a < b for N-bit two's-complement operands, correct across the full signed range.
// Latency: combinational.
// Backpressure: none (pure function of a and b).
module slt #(
   parameter int N = 32
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic         lt
);
   logic [N-1:0] diff;
   logic         unused_diff_low;

   assign diff = a - b;
   // Opposite signs can overflow the subtraction; the sign of a alone decides then.
   assign lt = (a[N-1] ^ b[N-1]) ? a[N-1] : diff[N-1];
   assign unused_diff_low = ^diff[N-2:0];
endmodule

// Purpose: tracks signed min, max and saturating count of a stream; emits them after the last word.
// Latency: result valid the cycle after the last word is accepted; no extra pipeline.
// Backpressure: in_ready low while a result waits; result holds until out_ready, then re-arms.
module stream_minmax #(
   parameter int N = 32,
   parameter int C = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in_data,
   input  logic         in_last,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] out_min,
   output logic [N-1:0] out_max,
   output logic [C-1:0] out_count
);
   typedef enum logic [1:0] {
      S_FIRST,
      S_ACCUM,
      S_DONE
   } state_t;

   state_t       state_q;
   state_t       state_d;
   logic [N-1:0] min_q;
   logic [N-1:0] max_q;
   logic [C-1:0] cnt_q;
   logic         accept;
   logic         new_min;
   logic         new_max;

   slt #(.N(N)) u_lt_min (.a(in_data), .b(min_q),   .lt(new_min));
   slt #(.N(N)) u_lt_max (.a(max_q),   .b(in_data), .lt(new_max));

   assign accept = in_valid & in_ready;

   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         S_FIRST: begin
            in_ready = 1'b1;
            if (in_valid) state_d = in_last ? S_DONE : S_ACCUM;
         end
         S_ACCUM: begin
            in_ready = 1'b1;
            if (in_valid && in_last) state_d = S_DONE;
         end
         S_DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_d = S_FIRST;
         end
         default: state_d = S_FIRST;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_FIRST;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         min_q <= '0;
         max_q <= '0;
         cnt_q <= '0;
      end else if (accept) begin
         if (state_q == S_FIRST) begin
            min_q <= in_data;
            max_q <= in_data;
            cnt_q <= {{(C-1){1'b0}}, 1'b1};
         end else begin
            // Ties leave the registers untouched since slt is strict.
            if (new_min) min_q <= in_data;
            if (new_max) max_q <= in_data;
            if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   assign out_min   = min_q;
   assign out_max   = max_q;
   assign out_count = cnt_q;
endmodule

// File: tb/tb_stream_minmax.sv
// Scenario bench for stream_minmax with a narrow counter so saturation is reachable quickly.
module tb_stream_minmax;
   localparam int N = 32;
   localparam int C = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] in_data;
   logic         in_last;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] out_min;
   logic [N-1:0] out_max;
   logic [C-1:0] out_count;

   typedef struct {
      logic [N-1:0] mn;
      logic [N-1:0] mx;
      logic [C-1:0] cnt;
   } exp_t;

   exp_t exp_q[$];
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   stream_minmax #(.N(N), .C(C)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_min   (out_min),
      .out_max   (out_max),
      .out_count (out_count)
   );

   // Result handshakes are scored against the queue filled when each stream's last word is driven.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         exp_t e;
         tests++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL scoreboard: unexpected result min=%h max=%h cnt=%0d", out_min, out_max, out_count);
         end else begin
            e = exp_q.pop_front();
            if (out_min !== e.mn || out_max !== e.mx || out_count !== e.cnt) begin
               fails++;
               $display("FAIL scoreboard: got min=%h max=%h cnt=%0d, want min=%h max=%h cnt=%0d",
                        out_min, out_max, out_count, e.mn, e.mx, e.cnt);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [N-1:0] d, input logic last);
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic push(input logic [N-1:0] mn, input logic [N-1:0] mx, input int cnt);
      exp_t e;
      e.mn  = mn;
      e.mx  = mx;
      e.cnt = C'(cnt);
      exp_q.push_back(e);
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b1; in_data = 32'h55; in_last = 1'b0; out_ready = 1'b1;
      tick();
      tick();
      tests++;
      if (out_min !== '0 || out_max !== '0 || out_count !== '0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
         fails++;
         $display("FAIL reset: min=%h max=%h cnt=%0d ov=%b ir=%b, want 0 0 0 0 1",
                  out_min, out_max, out_count, out_valid, in_ready);
      end
      rst = 1'b0; in_valid = 1'b0;
      tick();
      tests++;
      if (out_count !== '0 || out_valid !== 1'b0) begin
         fails++;
         $display("FAIL reset_no_accept: cnt=%0d ov=%b, want 0 0", out_count, out_valid);
      end
   endtask

   task automatic test_basic();
      out_ready = 1'b1;
      send(32'd5, 1'b0);
      send(-32'sd3, 1'b0);
      send(32'd7, 1'b0);
      tests++;
      if (out_valid !== 1'b0) begin
         fails++;
         $display("FAIL basic_early_valid: out_valid=%b, want 0", out_valid);
      end
      push(32'hFFFF_FFFD, 32'd7, 4);
      send(32'd0, 1'b1);
      tests++;
      if (out_valid !== 1'b1 || out_min !== 32'hFFFF_FFFD || out_max !== 32'd7 || out_count !== 4'd4) begin
         fails++;
         $display("FAIL basic_result: ov=%b min=%h max=%h cnt=%0d, want 1 fffffffd 7 4",
                  out_valid, out_min, out_max, out_count);
      end
      tick();
      tests++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         fails++;
         $display("FAIL basic_release: ov=%b ir=%b, want 0 1", out_valid, in_ready);
      end
   endtask

   task automatic test_extremes();
      push(32'h8000_0000, 32'h7FFF_FFFF, 2);
      send(32'h7FFF_FFFF, 1'b0);
      send(32'h8000_0000, 1'b1);
      tests++;
      if (out_valid !== 1'b1 || out_min !== 32'h8000_0000 || out_max !== 32'h7FFF_FFFF) begin
         fails++;
         $display("FAIL extremes: ov=%b min=%h max=%h, want 1 80000000 7fffffff", out_valid, out_min, out_max);
      end
      tick();
   endtask

   task automatic test_single_and_ties();
      push(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
      send(32'hFFFF_FFFF, 1'b1);
      tests++;
      if (out_valid !== 1'b1 || out_count !== 4'd1 || out_min !== 32'hFFFF_FFFF) begin
         fails++;
         $display("FAIL single: ov=%b min=%h cnt=%0d, want 1 ffffffff 1", out_valid, out_min, out_count);
      end
      tick();
      push(32'd4, 32'd4, 3);
      for (int i = 0; i < 3; i++) send(32'd4, i == 2);
      tests++;
      if (out_min !== 32'd4 || out_max !== 32'd4 || out_count !== 4'd3) begin
         fails++;
         $display("FAIL ties: min=%h max=%h cnt=%0d, want 4 4 3", out_min, out_max, out_count);
      end
      tick();
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      push(32'd2, 32'd9, 2);
      send(32'd2, 1'b0);
      tick(); tick(); tick();
      send(32'd9, 1'b1);
      push(32'd100, 32'd100, 1);
      in_valid = 1'b1; in_data = 32'd100; in_last = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tests++;
         if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_min !== 32'd2 || out_max !== 32'd9 || out_count !== 4'd2) begin
            fails++;
            $display("FAIL hold[%0d]: ir=%b ov=%b min=%h max=%h cnt=%0d, want 0 1 2 9 2",
                     i, in_ready, out_valid, out_min, out_max, out_count);
         end
         tick();
      end
      out_ready = 1'b1;
      tick();
      tests++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_count !== 4'd2) begin
         fails++;
         $display("FAIL bubble: ov=%b ir=%b cnt=%0d, want 0 1 2", out_valid, in_ready, out_count);
      end
      tick();
      in_valid = 1'b0; in_last = 1'b0;
      tests++;
      if (out_valid !== 1'b1 || out_min !== 32'd100 || out_count !== 4'd1) begin
         fails++;
         $display("FAIL next_stream: ov=%b min=%h cnt=%0d, want 1 64 1", out_valid, out_min, out_count);
      end
      tick();
   endtask

   task automatic test_saturation();
      int mn, mx, v;
      mn = 0; mx = 0;
      for (int i = 0; i < 20; i++) begin
         v = (i * 7) % 23 - 11;
         if (i == 0 || v < mn) mn = v;
         if (i == 0 || v > mx) mx = v;
      end
      push(N'(mn), N'(mx), 15);
      for (int i = 0; i < 20; i++) send(N'((i * 7) % 23 - 11), i == 19);
      tests++;
      if (out_count !== 4'd15 || out_min !== N'(mn) || out_max !== N'(mx)) begin
         fails++;
         $display("FAIL saturation: cnt=%0d min=%h max=%h, want 15 %h %h", out_count, out_min, out_max, N'(mn), N'(mx));
      end
      tick();
   endtask

   task automatic test_reset_mid();
      send(32'd10, 1'b0);
      send(32'd20, 1'b0);
      send(32'd30, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tests++;
      if (out_count !== '0 || out_valid !== 1'b0) begin
         fails++;
         $display("FAIL mid_reset: cnt=%0d ov=%b, want 0 0", out_count, out_valid);
      end
      push(32'd8, 32'd8, 1);
      send(32'd8, 1'b1);
      tests++;
      if (out_min !== 32'd8 || out_max !== 32'd8 || out_count !== 4'd1) begin
         fails++;
         $display("FAIL after_reset: min=%h max=%h cnt=%0d, want 8 8 1", out_min, out_max, out_count);
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_extremes();
      test_single_and_ties();
      test_backpressure();
      test_saturation();
      test_reset_mid();
      tick();
      tick();
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL drain: %0d results never produced, want 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
